// File: rtl/cva6_rvfi_commit_sequencer_if.sv
// Commit-side and trace-side signal bundle for the RVFI commit sequencer.
// trace_* follows valid/ready: a record transfers on a cycle where trace_valid_o && trace_ready_i;
// while valid && !ready, trace_rec_o/trace_order_o hold. commit_* has no ready: commit cannot stall.
interface cva6_rvfi_commit_sequencer_if #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned RecWidth      = 128,
  parameter int unsigned OrderWidth    = 64
);
  logic [NrCommitPorts-1:0]          commit_valid_i;
  logic [NrCommitPorts*RecWidth-1:0] commit_rec_i;
  logic                              trace_valid_o;
  logic                              trace_ready_i;
  logic [RecWidth-1:0]               trace_rec_o;
  logic [OrderWidth-1:0]             trace_order_o;

  modport master (
    output commit_valid_i, commit_rec_i, trace_ready_i,
    input  trace_valid_o, trace_rec_o, trace_order_o
  );

  modport slave (
    input  commit_valid_i, commit_rec_i, trace_ready_i,
    output trace_valid_o, trace_rec_o, trace_order_o
  );
endinterface

// File: rtl/cva6_rvfi_commit_sequencer.sv
// Packs per-cycle retire records into one ordered trace stream through a FIFO,
// dropping whole cycles on overflow and resynchronising once the FIFO drains.
module cva6_rvfi_commit_sequencer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned RecWidth      = 128,
  parameter int unsigned Depth         = 8,
  parameter int unsigned OrderWidth    = 64,
  parameter int unsigned DropCntWidth  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  cva6_rvfi_commit_sequencer_if.slave bus,
  output logic                      almost_full_o,
  output logic                      overflow_o,
  output logic [DropCntWidth-1:0]   drop_cnt_o,
  output logic [$clog2(Depth):0]    count_o,
  output logic                      dbg_state_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {RUN = 1'b0, RESYNC = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [RecWidth-1:0]     rec_mem_q [Depth];
  logic [OrderWidth-1:0]   ord_mem_q [Depth];
  logic [AW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [OrderWidth-1:0]   order_q;
  logic                    overflow_q, overflow_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic [DropCntWidth:0]   drop_sum;
  logic [CW-1:0]           k, free;
  logic                    pop, push, drop, run_mode;
  logic [RecWidth-1:0]     slot_rec [NrCommitPorts];

  // Slot j receives the j-th valid port in ascending index order.
  always_comb begin
    k = '0;
    for (int j = 0; j < NrCommitPorts; j++) slot_rec[j] = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (bus.commit_valid_i[i]) begin
        for (int j = 0; j < NrCommitPorts; j++) begin
          if (int'(k) == j) slot_rec[j] = bus.commit_rec_i[i*RecWidth +: RecWidth];
        end
        k = k + CW'(1);
      end
    end
  end

  assign pop      = (count_q != '0) && bus.trace_ready_i;
  assign free     = CW'(Depth) - count_q + CW'(pop);
  assign run_mode = (state_q == RUN) || (count_q == '0);
  assign drop_sum = {1'b0, drop_cnt_q} + (DropCntWidth+1)'(k);

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    drop       = 1'b0;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (run_mode) begin
      state_d = RUN;
      if (k <= free) begin
        push = (k != '0);
      end else begin
        drop    = 1'b1;
        state_d = RESYNC;
      end
    end else begin
      drop = (k != '0);
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
    end
    count_d = count_q + (push ? k : CW'(0)) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= RUN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      order_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      order_q    <= order_q + OrderWidth'(k);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && push) begin
      for (int j = 0; j < NrCommitPorts; j++) begin
        if (j < int'(k)) begin
          rec_mem_q[wr_ptr_q + AW'(j)] <= slot_rec[j];
          ord_mem_q[wr_ptr_q + AW'(j)] <= order_q + OrderWidth'(j);
        end
      end
    end
  end

  // Empty FIFO presents zeros rather than stale storage.
  assign bus.trace_valid_o = (count_q != '0);
  assign bus.trace_rec_o   = bus.trace_valid_o ? rec_mem_q[rd_ptr_q] : '0;
  assign bus.trace_order_o = bus.trace_valid_o ? ord_mem_q[rd_ptr_q] : '0;
  assign almost_full_o     = (count_q > CW'(Depth - NrCommitPorts));
  assign overflow_o        = overflow_q;
  assign drop_cnt_o        = drop_cnt_q;
  assign count_o           = count_q;
  assign dbg_state_o       = (state_q == RESYNC);

`ifndef SYNTHESIS
  logic [OrderWidth-1:0] last_ord_q, ord_delta;
  logic                  seen_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      seen_q     <= 1'b0;
      last_ord_q <= '0;
    end else if (pop) begin
      seen_q     <= 1'b1;
      last_ord_q <= bus.trace_order_o;
    end
  end

  assign ord_delta = bus.trace_order_o - last_ord_q;

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(Depth));
  a_no_resync_push: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    (state_q == RESYNC && count_q != '0) |-> !push);
  a_order_rises: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    (pop && seen_q) |-> (ord_delta != '0 && !ord_delta[OrderWidth-1]));
`endif
endmodule

// File: tb/tb_cva6_rvfi_commit_sequencer.sv
// Directed bench for the commit sequencer: expected {order, rec} pairs are queued when
// commits are driven and compared whenever the sink accepts the head record.
module tb_cva6_rvfi_commit_sequencer;
  localparam int NCP = 2;
  localparam int RW  = 128;
  localparam int DEP = 8;
  localparam int OW  = 64;
  localparam int DW  = 16;
  localparam int EW  = OW + RW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          af, ovf, dbg;
  logic [DW-1:0] drop;
  logic [3:0]    cnt;

  cva6_rvfi_commit_sequencer_if #(.NrCommitPorts(NCP), .RecWidth(RW), .OrderWidth(OW)) bus ();

  cva6_rvfi_commit_sequencer #(
    .NrCommitPorts(NCP), .RecWidth(RW), .Depth(DEP), .OrderWidth(OW), .DropCntWidth(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus),
    .almost_full_o(af), .overflow_o(ovf), .drop_cnt_o(drop), .count_o(cnt), .dbg_state_o(dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [OW-1:0] exp_order = '0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one cycle of stimulus; scoreboard pop-compare happens before the edge that pops
  task automatic step(input logic [1:0] vld, input logic rdy, input bit accept);
    logic [RW-1:0] r [NCP];
    int j;
    j = 0;
    for (int i = 0; i < NCP; i++) r[i] = {$urandom, $urandom, $urandom, $urandom};
    bus.commit_valid_i = vld;
    bus.commit_rec_i   = {r[1], r[0]};
    bus.trace_ready_i  = rdy;
    if (rst_n && !clear) begin
      if (bus.trace_valid_o && rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_pop observed=%0h expected=none", {bus.trace_order_o, bus.trace_rec_o});
        end else begin
          chk("pop", {bus.trace_order_o, bus.trace_rec_o}, exp_q.pop_front());
        end
      end
      for (int i = 0; i < NCP; i++) begin
        if (vld[i]) begin
          if (accept) exp_q.push_back({exp_order + OW'(j), r[i]});
          j++;
        end
      end
      exp_order = exp_order + OW'(j);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(2'b00, rdy, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2'b11, 1'b1, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_order = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, cnt, 0);
    chk({tag, "_valid"}, bus.trace_valid_o, 0);
    chk({tag, "_rec"}, bus.trace_rec_o, 0);
    chk({tag, "_order"}, bus.trace_order_o, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_af"}, af, 0);
    chk({tag, "_state"}, dbg, 0);
  endtask

  initial begin
    bus.commit_valid_i = '0;
    bus.commit_rec_i   = '0;
    bus.trace_ready_i  = 1'b0;

    // reset and simple two-wide commit
    do_reset();
    chk_zero("reset");
    step(2'b11, 1'b1, 1'b1);
    chk("latency_valid", bus.trace_valid_o, 1);
    chk("latency_count", cnt, 2);
    idle(2, 1'b1);
    chk("ab_drained", cnt, 0);
    chk("ab_ovf", ovf, 0);

    // port 0 idle, port 1 only: order 2
    step(2'b10, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("c_drained", cnt, 0);
    chk("c_queue", exp_q.size(), 0);

    // fill, overflow, resync
    do_reset();
    repeat (3) step(2'b11, 1'b0, 1'b1);
    chk("fill6_count", cnt, 6);
    chk("fill6_af", af, 0);
    step(2'b11, 1'b0, 1'b1);
    chk("full_count", cnt, 8);
    chk("full_af", af, 1);
    step(2'b11, 1'b0, 1'b0);
    chk("ovf_count", cnt, 8);
    chk("ovf_flag", ovf, 1);
    chk("ovf_drop", drop, 2);
    chk("ovf_state", dbg, 1);
    idle(8, 1'b1);
    chk("resync_empty", cnt, 0);
    chk("resync_state_held", dbg, 1);
    step(2'b11, 1'b1, 1'b1);
    chk("resync_exit_state", dbg, 0);
    chk("resync_exit_ovf", ovf, 1);
    idle(2, 1'b1);
    chk("gap_queue", exp_q.size(), 0);
    chk("gap_count", cnt, 0);

    // pop-through on full FIFO
    do_reset();
    repeat (4) step(2'b11, 1'b0, 1'b1);
    step(2'b01, 1'b1, 1'b1);
    chk("pt_count", cnt, 8);
    chk("pt_ovf", ovf, 0);
    chk("pt_drop", drop, 0);
    idle(8, 1'b1);
    chk("pt_queue", exp_q.size(), 0);

    // clear mid-burst while in RESYNC with 5 entries
    do_reset();
    repeat (4) step(2'b11, 1'b0, 1'b1);
    step(2'b11, 1'b0, 1'b0);
    idle(3, 1'b1);
    chk("pre_clear_count", cnt, 5);
    clear = 1'b1;
    step(2'b11, 1'b0, 1'b0);
    clear = 1'b0;
    exp_q.delete();
    exp_order = '0;
    chk_zero("clear");
    step(2'b01, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("post_clear_queue", exp_q.size(), 0);

    // drop counter saturation, then reset in RESYNC
    do_reset();
    repeat (4) step(2'b11, 1'b0, 1'b1);
    step(2'b11, 1'b0, 1'b0);
    chk("sat_first_drop", drop, 2);
    repeat (32766) step(2'b11, 1'b0, 1'b0);
    chk("sat_fffe", drop, 16'hFFFE);
    repeat (2) step(2'b11, 1'b0, 1'b0);
    chk("sat_ffff", drop, 16'hFFFF);
    chk("sat_state", dbg, 1);
    chk("sat_count", cnt, 8);
    do_reset();
    chk_zero("rst_resync");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
